// File: rtl/cache_pkg.sv
// Shared types for the cache fill controller.
// Widths, controller states and fill timeout helper.
package cache_pkg;

  localparam int ADDR_W = 8;
  localparam int VAL_W  = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [VAL_W-1:0]  val_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM,
    FILL,
    FILL_WAIT,
    RESP
  } ctrl_state_t;

  function automatic int fill_limit(input int k);
    return 2 * k + 2;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // count up on inc, hold at the top value
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Requester-side controller: probe cache, fetch on miss,
// write-through with allocate, saturating hit/miss stats.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K          = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [LINE_WIDTH-1:0] cache_val,
  output logic                  cache_read,
  output logic                  cache_write,
  input  logic                  cache_hit,
  input  logic [LINE_WIDTH-1:0] cache_out_val,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int FL = fill_limit(K);
  localparam int FW = $clog2(FL + 1);
  localparam logic [FW-1:0] LAST = FW'(FL - 1);

  ctrl_state_t           state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LINE_WIDTH-1:0] wdata;
  logic                  is_wr;
  logic [FW-1:0]         fill_cnt;
  logic                  hit_inc;
  logic                  miss_inc;

  assign req_ready = (state == IDLE);
  assign hit_inc   = (state == CHECK) && cache_hit;
  assign miss_inc  = (state == CHECK) && !cache_hit;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

  // request FSM; all outputs registered on the state transition
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      wdata       <= '0;
      is_wr       <= 1'b0;
      fill_cnt    <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_req     <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cache_addr  <= '0;
      cache_val   <= '0;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr  <= req_addr;
            wdata <= req_wdata;
            is_wr <= req_write;
            if (req_write) begin
              state     <= MEM;
              mem_req   <= 1'b1;
              mem_write <= 1'b1;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
            end else begin
              state      <= LOOKUP;
              cache_read <= 1'b1;
              cache_addr <= req_addr;
            end
          end
        end
        LOOKUP: begin
          cache_read <= 1'b0;
          state      <= CHECK;
        end
        CHECK: begin
          if (cache_hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= cache_out_val;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else begin
            mem_req   <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            state     <= MEM;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            cache_write <= 1'b1;
            cache_addr  <= addr;
            cache_val   <= is_wr ? wdata : mem_rdata;
            state       <= FILL;
          end
        end
        FILL: begin
          fill_cnt <= FW'(1);
          state    <= FILL_WAIT;
        end
        FILL_WAIT: begin
          fill_cnt <= fill_cnt + FW'(1);
          if (cache_hit || fill_cnt == LAST) begin
            cache_write <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= !cache_hit;
            resp_rdata  <= is_wr ? '0 : cache_val;
            state       <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl with a behavioural
// cache stub, backing memory and transaction-level model.
module tb_cache_fill_ctrl;

  localparam int AW   = 8;
  localparam int LW   = 32;
  localparam int K    = 2;
  localparam int CW   = 3;
  localparam int FL   = 2 * K + 2;
  localparam int CAP  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid;
  logic [LW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;
  logic [AW-1:0] cache_addr;
  logic [LW-1:0] cache_val;
  logic          cache_read;
  logic          cache_write;
  logic          cache_hit;
  logic [LW-1:0] cache_out_val;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  always #5 clock = ~clock;

  cache_fill_ctrl #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .K          (K),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .cache_addr    (cache_addr),
    .cache_val     (cache_val),
    .cache_read    (cache_read),
    .cache_write   (cache_write),
    .cache_hit     (cache_hit),
    .cache_out_val (cache_out_val),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // environment state shared with the driver
  logic [LW-1:0] mem_model [256];
  logic [AW-1:0] cur_addr;
  logic          cur_write;
  logic [LW-1:0] cur_wdata;
  int            mem_delay = 0;
  int            wr_lat = 0;
  bit            stuck = 1'b0;
  bit            spur = 1'b1;
  int            exp_hit = 0;
  int            exp_miss = 0;
  int            both_hi = 0;

  // cache stub: small FIFO-replacement store, registered sticky hit
  logic [AW-1:0] c_tag [CAP];
  logic [LW-1:0] c_val [CAP];
  bit            c_v   [CAP];
  int            c_ptr = 0;
  bit            in_wr;
  int            wr_cnt;

  function automatic int find(input logic [AW-1:0] a);
    for (int i = 0; i < CAP; i++)
      if (c_v[i] && c_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [LW-1:0] rd_val(input logic [AW-1:0] a);
    for (int i = 0; i < CAP; i++)
      if (c_v[i] && c_tag[i] == a) return c_val[i];
    return '0;
  endfunction

  task automatic install(input logic [AW-1:0] a,
                         input logic [LW-1:0] v);
    int i;
    i = find(a);
    if (i >= 0) begin
      c_val[i] <= v;
    end else begin
      c_tag[c_ptr] <= a;
      c_val[c_ptr] <= v;
      c_v[c_ptr]   <= 1'b1;
      c_ptr        <= (c_ptr + 1) % CAP;
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      cache_hit     <= 1'b0;
      cache_out_val <= '0;
      in_wr         <= 1'b0;
      wr_cnt        <= 0;
    end else if (cache_read) begin
      cache_hit     <= (find(cache_addr) >= 0);
      cache_out_val <= rd_val(cache_addr);
      in_wr         <= 1'b0;
    end else if (cache_write) begin
      in_wr  <= 1'b1;
      wr_cnt <= (in_wr ? wr_cnt : 0) + 1;
      if (!stuck && (in_wr ? wr_cnt : 0) >= wr_lat) begin
        install(cache_addr, cache_val);
        cache_hit <= 1'b1;
      end else begin
        cache_hit <= 1'b0;
      end
    end else begin
      in_wr <= 1'b0;
    end
  end

  // backing memory: ack after mem_delay extra cycles, stray acks when idle
  initial begin
    int mwait;
    mwait = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req) begin
        if (mwait == mem_delay) begin
          mem_ack = 1'b1;
          chk("mem_addr", mem_addr, cur_addr);
          chk("mem_write", mem_write, cur_write);
          if (mem_write) begin
            chk("mem_wdata", mem_wdata, cur_wdata);
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem_model[mem_addr];
          end
          mwait = 0;
        end else begin
          mem_ack = 1'b0;
          mwait++;
        end
      end else begin
        mwait = 0;
        mem_ack = spur && ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cache_read && cache_write) both_hi++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // one request end to end, checked against the transaction model
  task automatic txn(input bit wr, input logic [AW-1:0] a,
                     input logic [LW-1:0] wd, input int lat,
                     input int d, input bit stk, input bit hold);
    bit            hit;
    int            fill_cyc, exp_lat, cyc, n, mc, wc;
    logic [LW-1:0] exp_rd;
    hit      = !wr && (find(a) >= 0);
    fill_cyc = stk ? FL : lat + 2;
    if (hit)     exp_lat = 3;
    else if (wr) exp_lat = (d + 1) + fill_cyc + 1;
    else         exp_lat = 3 + (d + 1) + fill_cyc;
    exp_rd = wr ? '0 : mem_model[a];
    if (!wr) begin
      if (hit) exp_hit = sat_inc(exp_hit);
      else     exp_miss = sat_inc(exp_miss);
    end
    cur_addr  = a;
    cur_write = wr;
    cur_wdata = wd;
    wr_lat    = lat;
    mem_delay = d;
    stuck     = stk;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_ready", req_ready, 1'b1);
    @(negedge clock);
    if (!hold) begin
      req_valid = 1'b0;
      req_write = $urandom;
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    cyc = 1;
    mc = 0;
    wc = 0;
    while (!resp_valid && cyc < 120) begin
      mc += int'(mem_req);
      wc += int'(cache_write);
      @(negedge clock);
      cyc++;
    end
    chk("resp_latency", cyc, exp_lat);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", resp_err, stk);
    chk("mem_req_cycles", mc, hit ? 0 : d + 1);
    chk("fill_cycles", wc, hit ? 0 : fill_cyc);
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
    chk("ready_in_resp", req_ready, 1'b0);
    @(negedge clock);
    chk("resp_pulse", resp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
    req_valid = 1'b0;
    @(negedge clock);
    chk("no_reaccept", mem_req | cache_read, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] pool [4];
    int            n;
    pool[0] = 8'h10;
    pool[1] = 8'h20;
    pool[2] = 8'h30;
    pool[3] = 8'h40;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    mem_model[8'h10] = 32'hDEADBEEF;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    cur_addr = '0;
    cur_write = 1'b0;
    cur_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, '0);
    chk("rst_mem", {mem_req, mem_write, mem_addr, mem_wdata}, '0);
    chk("rst_cache", {cache_read, cache_write, cache_addr, cache_val}, '0);
    chk("rst_counts", {hit_count, miss_count}, '0);
    reset = 1'b0;
    @(negedge clock);

    txn(1'b0, 8'h10, '0, 1, 2, 1'b0, 1'b0);
    txn(1'b0, 8'h10, '0, 0, 0, 1'b0, 1'b0);
    txn(1'b1, 8'h20, 32'h12345678, 0, 1, 1'b0, 1'b0);
    txn(1'b0, 8'h20, '0, 2, 0, 1'b0, 1'b0);
    txn(1'b0, 8'h30, '0, 3, 1, 1'b0, 1'b0);
    txn(1'b0, 8'h10, '0, 1, 0, 1'b0, 1'b0);
    txn(1'b0, 8'h50, '0, 0, 1, 1'b1, 1'b0);
    txn(1'b1, 8'h60, 32'hA5A5_0F0F, 0, 0, 1'b1, 1'b0);
    txn(1'b0, 8'h10, '0, 0, 0, 1'b0, 1'b1);

    // reset while waiting on memory
    cur_addr = 8'h77;
    cur_write = 1'b0;
    mem_delay = 40;
    stuck = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 8'h77;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("pre_rst_memreq", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_memreq", mem_req, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_counts", {hit_count, miss_count}, '0);
    chk("mid_rst_cache", {cache_read, cache_write}, '0);
    reset = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    repeat (5) @(negedge clock);
    chk("late_ack_memreq", mem_req, 1'b0);
    chk("late_ack_ready", req_ready, 1'b1);
    chk("late_ack_resp", resp_valid, 1'b0);

    for (int t = 0; t < 60; t++) begin
      txn(($urandom_range(0, 2) == 0), pool[$urandom_range(0, 3)],
          $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          1'b0, $urandom_range(0, 1));
    end
    chk("rw_exclusive", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
